// File: rtl/geofence_pkg.sv
// Shared types and sizing helpers for the geofence_n point-in-convex-polygon engine.
`timescale 1ns/1ps
package geofence_pkg;

   typedef enum logic [1:0] {READ, SORT, CHECK, OUT} state_e;

   function automatic int cross_w(input int w);
      return 2 * w + 3;
   endfunction

   function automatic int sort_pairs(input int n);
      return (n - 1) * (n - 2) / 2;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DEF_W   = 10;
   localparam int DEF_N   = 6;
   localparam int CROSS_W = cross_w(DEF_W);
   localparam int SORT_S  = sort_pairs(DEF_N);
   localparam int CNT_W   = cnt_w(DEF_N);

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed 2-D cross product a.x*b.y - a.y*b.x of (W+1)-bit difference vectors.
`timescale 1ns/1ps
module geofence_cross
   import geofence_pkg::*;
#(
   parameter int W = 10
) (
   input  logic signed [W:0]              ax,
   input  logic signed [W:0]              ay,
   input  logic signed [W:0]              bx,
   input  logic signed [W:0]              by,
   output logic signed [cross_w(W)-1:0]   c
);
   localparam int PW = 2 * W + 2;
   localparam int CW = cross_w(W);

   logic signed [PW-1:0] p_ab;
   logic signed [PW-1:0] p_ba;

   always_comb begin
      p_ab = $signed(PW'(ax)) * $signed(PW'(by));
      p_ba = $signed(PW'(ay)) * $signed(PW'(bx));
      c    = $signed(CW'(p_ab)) - $signed(CW'(p_ba));
   end

endmodule

// File: rtl/geofence_n.sv
// Point-in-convex-polygon engine: collects target + N vertices, angle-sorts them, then
// tests the target against every edge and strobes inside / on-edge.
`timescale 1ns/1ps
module geofence_n
   import geofence_pkg::*;
#(
   parameter int W = 10,
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   output logic         valid,
   output logic         is_inside,
   output logic         on_edge
);
   localparam int CW = cross_w(W);
   localparam int NW = cnt_w(N);
   localparam int IW = $clog2(N);

   typedef logic signed [W:0] diff_t;

   state_e               state_q, state_d;
   logic [NW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
   logic [IW-1:0]        kn, wr_idx;
   logic [W-1:0]         vx_q [N];
   logic [W-1:0]         vx_d [N];
   logic [W-1:0]         vy_q [N];
   logic [W-1:0]         vy_d [N];
   logic [W-1:0]         tx_q, tx_d, ty_q, ty_d;
   logic                 neg_q, neg_d, zero_q, zero_d;
   logic                 valid_q, valid_d, inside_q, inside_d, edge_q, edge_d;
   diff_t                ax, ay, bx, by;
   logic signed [CW-1:0] cr;

   function automatic diff_t sub(input logic [W-1:0] a, input logic [W-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // One cross-product unit serves both phases: angular compare in SORT, edge test in CHECK.
   always_comb begin
      kn     = (k_q == IW'(N - 1)) ? '0 : k_q + IW'(1);
      wr_idx = IW'(cnt_q - NW'(1));
      if (state_q == CHECK) begin
         ax = sub(vx_q[kn], vx_q[k_q]);
         ay = sub(vy_q[kn], vy_q[k_q]);
         bx = sub(tx_q, vx_q[k_q]);
         by = sub(ty_q, vy_q[k_q]);
      end else begin
         ax = sub(vx_q[i_q], vx_q[0]);
         ay = sub(vy_q[i_q], vy_q[0]);
         bx = sub(vx_q[j_q], vx_q[0]);
         by = sub(vy_q[j_q], vy_q[0]);
      end
   end

   geofence_cross #(.W(W)) u_cross (
      .ax (ax),
      .ay (ay),
      .bx (bx),
      .by (by),
      .c  (cr)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      vx_d     = vx_q;
      vy_d     = vy_q;
      tx_d     = tx_q;
      ty_d     = ty_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;
      inside_d = inside_q;
      edge_d   = edge_q;
      case (state_q)
         READ: begin
            if (in_valid) begin
               if (cnt_q == '0) begin
                  tx_d = X;
                  ty_d = Y;
               end else begin
                  vx_d[wr_idx] = X;
                  vy_d[wr_idx] = Y;
               end
               if (cnt_q == NW'(N)) begin
                  state_d = SORT;
                  cnt_d   = '0;
                  i_d     = IW'(1);
                  j_d     = IW'(2);
               end else begin
                  cnt_d = cnt_q + NW'(1);
               end
            end
         end
         SORT: begin
            // Negative cross means v[j] lies clockwise of v[i] about v[0]: swap for CCW order.
            if (cr[CW-1]) begin
               vx_d[i_q] = vx_q[j_q];
               vy_d[i_q] = vy_q[j_q];
               vx_d[j_q] = vx_q[i_q];
               vy_d[j_q] = vy_q[i_q];
            end
            if (j_q == IW'(N - 1)) begin
               if (i_q == IW'(N - 2)) begin
                  state_d = CHECK;
                  k_d     = '0;
               end else begin
                  i_d = i_q + IW'(1);
                  j_d = i_q + IW'(2);
               end
            end else begin
               j_d = j_q + IW'(1);
            end
         end
         CHECK: begin
            neg_d  = neg_q | cr[CW-1];
            zero_d = zero_q | (cr == '0);
            if (k_q == IW'(N - 1)) state_d = OUT;
            else                   k_d     = k_q + IW'(1);
         end
         OUT: begin
            valid_d  = 1'b1;
            inside_d = !neg_q && !zero_q;
            edge_d   = !neg_q && zero_q;
            neg_d    = 1'b0;
            zero_d   = 1'b0;
            state_d  = READ;
         end
         default: state_d = READ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= READ;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
         valid_q  <= 1'b0;
         inside_q <= 1'b0;
         edge_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         i_q      <= i_d;
         j_q      <= j_d;
         k_q      <= k_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         tx_q     <= tx_d;
         ty_q     <= ty_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
         inside_q <= inside_d;
         edge_q   <= edge_d;
      end
   end

   assign in_ready  = (state_q == READ);
   assign valid     = valid_q;
   assign is_inside = inside_q;
   assign on_edge   = edge_q;

endmodule

// File: tb/tb_geofence_n.sv
// Directed scoreboard bench for geofence_n: hexagon (N=6), triangle (N=3, W=12), square (N=4).
`timescale 1ns/1ps
module tb_geofence_n;

   typedef struct {
      logic ins;
      logic edg;
      int   cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_acc = 0;

   logic        iv6, rdy6, v6, in6, ed6;
   logic [9:0]  x6, y6;
   logic        iv3, rdy3, v3, in3, ed3;
   logic [11:0] x3, y3;
   logic        iv4, rdy4, v4, in4, ed4;
   logic [9:0]  x4, y4;

   exp_t q6[$], q3[$], q4[$];
   exp_t e6, e3, e4;
   int   s3[$];

   int hx[8] = '{200, 100,   0, 300, 100, 200, 0, 0};
   int hy[8] = '{200,   0, 100, 100, 200,   0, 0, 0};
   int tx3[8] = '{0, 4095,    0, 0, 0, 0, 0, 0};
   int ty3[8] = '{0,    0, 4095, 0, 0, 0, 0, 0};
   int sqx[8] = '{0, 1023, 1023,    0, 0, 0, 0, 0};
   int sqy[8] = '{0,    0, 1023, 1023, 0, 0, 0, 0};

   geofence_n #(.W(10), .N(6)) dut6 (
      .clk(clk), .reset(reset), .in_valid(iv6), .in_ready(rdy6), .X(x6), .Y(y6),
      .valid(v6), .is_inside(in6), .on_edge(ed6));
   geofence_n #(.W(12), .N(3)) dut3 (
      .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(rdy3), .X(x3), .Y(y3),
      .valid(v3), .is_inside(in3), .on_edge(ed3));
   geofence_n #(.W(10), .N(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rdy4), .X(x4), .Y(y4),
      .valid(v4), .is_inside(in4), .on_edge(ed4));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int n);
      return (n - 1) * (n - 2) / 2 + n + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int w);
      case (w)
         0:       return q6.size();
         1:       return q3.size();
         default: return q4.size();
      endcase
   endfunction

   function automatic logic rdy(input int w);
      case (w)
         0:       return rdy6;
         1:       return rdy3;
         default: return rdy4;
      endcase
   endfunction

   task automatic set_in(input int w, input logic v, input int x, input int y);
      case (w)
         0:       begin iv6 = v; x6 = 10'(x); y6 = 10'(y); end
         1:       begin iv3 = v; x3 = 12'(x); y3 = 12'(y); end
         default: begin iv4 = v; x4 = 10'(x); y4 = 10'(y); end
      endcase
   endtask

   task automatic send_sample(input int w, input int x, input int y);
      logic ok;
      ok = 1'b0;
      set_in(w, 1'b1, x, y);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rdy(w) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_wait", ok, 1);
      @(posedge clk); #1;
      last_acc = cyc;
      set_in(w, 1'b0, 0, 0);
   endtask

   task automatic send_frame(input int w, input int tx, input int ty, input int vx[8], input int vy[8],
                             input int n, input bit push, input logic ei, input logic ee,
                             input int gap_after, input int gap_len);
      exp_t e;
      send_sample(w, tx, ty);
      for (int s = 1; s <= n; s++) begin
         send_sample(w, vx[s-1], vy[s-1]);
         if (s == gap_after) begin
            repeat (gap_len) @(posedge clk);
            #1;
         end
      end
      if (push) begin
         e.ins = ei;
         e.edg = ee;
         e.cyc = last_acc + lat(n);
         case (w)
            0:       q6.push_back(e);
            1:       q3.push_back(e);
            default: q4.push_back(e);
         endcase
      end
   endtask

   task automatic wait_idle(input int w);
      int k;
      k = 0;
      while (qsize(w) != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("strobe_pending", qsize(w), 0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (v6 === 1'b1) begin
         if (q6.size() == 0) chk("spurious_strobe6", v6, 0);
         else begin
            e6 = q6.pop_front();
            chk("inside6", in6, e6.ins);
            chk("edge6", ed6, e6.edg);
            chk("latency6", cyc, e6.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (v3 === 1'b1) begin
         s3.push_back(cyc);
         if (q3.size() == 0) chk("spurious_strobe3", v3, 0);
         else begin
            e3 = q3.pop_front();
            chk("inside3", in3, e3.ins);
            chk("edge3", ed3, e3.edg);
            chk("latency3", cyc, e3.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (v4 === 1'b1) begin
         if (q4.size() == 0) chk("spurious_strobe4", v4, 0);
         else begin
            e4 = q4.pop_front();
            chk("inside4", in4, e4.ins);
            chk("edge4", ed4, e4.edg);
            chk("latency4", cyc, e4.cyc);
         end
      end
   end

   initial begin
      reset = 1'b0;
      set_in(0, 1'b0, 0, 0);
      set_in(1, 1'b0, 0, 0);
      set_in(2, 1'b0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid6", v6, 0);
      chk("rst_inside6", in6, 0);
      chk("rst_edge6", ed6, 0);
      chk("rst_valid3", v3, 0);
      chk("rst_valid4", v4, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ready6_after_reset", rdy6, 1);

      send_frame(0, 150, 100, hx, hy, 6, 1'b1, 1'b1, 1'b0, -1, 0);
      wait_idle(0);
      send_frame(0, 400, 100, hx, hy, 6, 1'b1, 1'b0, 1'b0, -1, 0);
      wait_idle(0);
      send_frame(0, 150, 0, hx, hy, 6, 1'b1, 1'b0, 1'b1, -1, 0);
      wait_idle(0);
      send_frame(0, 100, 0, hx, hy, 6, 1'b1, 1'b0, 1'b1, -1, 0);
      wait_idle(0);
      send_frame(0, 150, 100, hx, hy, 6, 1'b1, 1'b1, 1'b0, 3, 3);
      wait_idle(0);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_inside6", in6, 1);
      chk("hold_valid6", v6, 0);

      // Abort a frame mid-SORT; a junk sample offered during reset must be ignored.
      send_frame(0, 400, 100, hx, hy, 6, 1'b0, 1'b0, 1'b0, -1, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      set_in(0, 1'b1, 700, 700);
      @(posedge clk); #1;
      reset = 1'b1;
      set_in(0, 1'b0, 0, 0);
      chk("abort_valid6", v6, 0);
      chk("abort_inside6", in6, 0);
      chk("abort_edge6", ed6, 0);
      chk("abort_ready6", rdy6, 1);
      repeat (30) @(posedge clk);
      #1;
      send_frame(0, 150, 0, hx, hy, 6, 1'b1, 1'b0, 1'b1, -1, 0);
      wait_idle(0);

      send_frame(1, 1, 1, tx3, ty3, 3, 1'b1, 1'b1, 1'b0, -1, 0);
      send_frame(1, 4095, 4095, tx3, ty3, 3, 1'b1, 1'b0, 1'b0, -1, 0);
      wait_idle(1);
      chk("strobes3", s3.size(), 2);
      if (s3.size() == 2) chk("spacing3", s3[1] - s3[0], 4 + lat(3));

      send_frame(2, 1023, 512, sqx, sqy, 4, 1'b1, 1'b0, 1'b1, -1, 0);
      wait_idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
